cpu6502_int_seq: RTL and testbench
==================================

// Module: cpu6502_int_seq
// PURPOSE
//  Interrupt/reset sequencer for the cpu6502 core, parametrised in IRQ source count and vectoring mode.
//  Replaces the fixed reset_f/vector_lo logic: arbitrates RESET > NMI > IRQ and requests a forced-BRK sequence.
//  Supplies the vector low byte, the pushed B-flag value and the write-inhibit for reset stack cycles.
//  Sits beside the microcode sequencer; the CPU drives the strobes, this block owns all pending state.
// PARAMETERS
//  NUM_IRQ       4      number of level-sensitive IRQ sources (1..8)
//  VECTORED      0      0: every IRQ uses $FE; 1: IRQ source n uses VEC_IRQ_BASE+2n
//  VEC_IRQ_BASE  8'hE0  base vector low byte for vectored IRQs (VECTORED=1 only)
//  NMI_SYNC      2      NMI synchroniser depth in flops (>=1)
// PORTS
//  clk          in   1        core clock
//  reset        in   1        synchronous, active-high reset
//  nmi          in   1        asynchronous NMI request, rising-edge sensitive
//  irq_src      in   NUM_IRQ  level IRQ requests, active high
//  i_flag       in   1        P.I from the core; 1 blocks IRQ (never NMI/RESET)
//  mask_we      in   1        write enable for the IRQ mask register
//  mask_wdata   in   NUM_IRQ  new mask; bit=1 masks that source
//  sample       in   1        core at final cycle of an instruction (t==0 fetch point)
//  vec_lo_stb   in   1        core fetching vector low byte this cycle
//  vec_hi_stb   in   1        core fetching vector high byte this cycle
//  int_req      out  1        force next opcode to BRK ($00) and run interrupt sequence
//  int_kind     out  2        0 none/BRK, 1 IRQ, 2 NMI, 3 RESET
//  vector_lo    out  8        vector low byte to drive ADL during vec_lo_stb (|1 for high)
//  push_b       out  1        B value for the P push: 1 for software BRK, 0 for hardware
//  wr_inhibit   out  1        1 during RESET sequences: stack pushes become reads
//  irq_id       out  3        source index of the serviced IRQ (valid when int_kind==1)
//  irq_pending  out  NUM_IRQ  irq_src & ~mask, raw view for software/debug
// BEHAVIOUR
//  Reset (while reset=1): state=IDLE, mask=all 1s, nmi_latch=0, sync flops=0, rst_pend=1;
//   outputs: int_req=0, int_kind=0, vector_lo=$FE, push_b=1, wr_inhibit=0, irq_id=0.
//  NMI: rising edge at last sync stage sets nmi_latch; held until serviced; a second edge while latched is merged.
//  irq_ok = |(irq_src & ~mask) & ~i_flag, evaluated combinationally each cycle, never latched.
//  irq_id candidate = lowest index n with irq_src[n]&~mask[n].
//  FSM IDLE -> PEND -> SERVE -> IDLE:
//   IDLE: on sample with (rst_pend|nmi_latch|irq_ok): go PEND next cycle, int_req=1,
//     int_kind = RESET if rst_pend, else NMI if nmi_latch, else IRQ. No request: stay IDLE.
//   PEND: int_kind upgrades IRQ->NMI if nmi_latch sets before vec_lo_stb (NMI hijack);
//     IRQ dropping or i_flag rising in PEND does NOT cancel (sequence already committed).
//     On vec_lo_stb: freeze vector_lo and irq_id; clear nmi_latch if NMI, rst_pend if RESET; -> SERVE.
//   SERVE: on vec_hi_stb -> IDLE next cycle; int_req, int_kind, wr_inhibit drop to 0 same edge.
//  vector_lo: RESET $FC, NMI $FA, IRQ $FE (VECTORED=0) or VEC_IRQ_BASE+{irq_id,1'b0}, none $FE.
//  push_b = ~int_req; wr_inhibit = int_req & (int_kind==RESET).
//  Latency: sample in cycle N -> int_req=1 in cycle N+1 (registered output).
//  sample while PEND/SERVE is ignored; vec_*_stb in IDLE is ignored (software BRK uses $FE).
//  mask_we takes effect next cycle; same-cycle mask write and sample use the old mask.
//  NMI edge in the same cycle as its vec_lo_stb clear: latch stays set (new edge wins).
//  reset mid-sequence: immediate return to reset state; the following sequence is RESET.
//  Vectored address arithmetic is 8-bit modulo; no overflow detection.
// TESTING
//  reset 3 cycles, release, sample -> int_kind=3, vector_lo=$FC, wr_inhibit=1 until vec_hi_stb.
//  irq_src=4'b0100, mask=0, i_flag=0, VECTORED=1, sample -> int_kind=1, irq_id=2, vector_lo=$E4, push_b=0.
//  irq_src=4'b0001, i_flag=1, sample -> int_req stays 0; nmi pulse then sample after NMI_SYNC+1 cycles -> int_kind=2, vector_lo=$FA.
//  IRQ sequence in PEND, nmi edge 1 cycle before vec_lo_stb -> vector_lo=$FA, nmi_latch cleared after stb.
//  mask_wdata=4'b1111 with irq_src=4'b1111 -> irq_pending=0, no int_req; unmask bit 3 -> irq_id=3.
//  reset asserted during SERVE of an NMI -> outputs to reset values, next sample gives int_kind=3.

Source files
------------

// File: rtl/cpu6502_int_seq.sv
// Interrupt/reset sequencer for the cpu6502 core: arbitrates RESET > NMI > IRQ, requests a forced
// BRK and supplies vector low byte, pushed B flag and reset-time stack write inhibit.
module cpu6502_int_seq #(
    parameter int unsigned NUM_IRQ      = 4,
    parameter int unsigned VECTORED     = 0,
    parameter logic [7:0]  VEC_IRQ_BASE = 8'hE0,
    parameter int unsigned NMI_SYNC     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               nmi,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic               i_flag,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               sample,
    input  logic               vec_lo_stb,
    input  logic               vec_hi_stb,
    output logic               int_req,
    output logic [1:0]         int_kind,
    output logic [7:0]         vector_lo,
    output logic               push_b,
    output logic               wr_inhibit,
    output logic [2:0]         irq_id,
    output logic [NUM_IRQ-1:0] irq_pending
);

    typedef enum logic [1:0] {
        StIdle,
        StPend,
        StServe
    } state_e;

    localparam logic [1:0] KindNone  = 2'd0;
    localparam logic [1:0] KindIrq   = 2'd1;
    localparam logic [1:0] KindNmi   = 2'd2;
    localparam logic [1:0] KindReset = 2'd3;

    state_e               state_q, state_d;
    logic [1:0]           kind_q, kind_d, kind_eff;
    logic [2:0]           irq_id_q, irq_id_d;
    logic [NUM_IRQ-1:0]   mask_q, mask_d;
    logic [NMI_SYNC-1:0]  nmi_sync_q, nmi_sync_d;
    logic                 nmi_last_q;
    logic                 nmi_latch_q, nmi_latch_d;
    logic                 rst_pend_q, rst_pend_d;
    logic                 nmi_rise;
    logic                 nmi_clear;
    logic                 irq_ok;
    logic [2:0]           cand_id;

    // NMI synchroniser chain; the extra flop gives the edge detector its previous sample
    always_comb begin
        nmi_sync_d    = nmi_sync_q;
        nmi_sync_d[0] = nmi;
        for (int i = 1; i < int'(NMI_SYNC); i++) begin
            nmi_sync_d[i] = nmi_sync_q[i-1];
        end
    end

    assign nmi_rise    = nmi_sync_q[NMI_SYNC-1] & ~nmi_last_q;
    assign irq_pending = irq_src & ~mask_q;
    assign irq_ok      = (|irq_pending) & ~i_flag;

    // Lowest-index pending source wins
    always_comb begin
        cand_id = 3'd0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (irq_pending[i]) begin
                cand_id = 3'(i);
            end
        end
    end

    // An NMI arriving before the vector fetch hijacks a committed IRQ sequence
    always_comb begin
        kind_eff = kind_q;
        if (state_q == StPend && kind_q == KindIrq && nmi_latch_q) begin
            kind_eff = KindNmi;
        end
    end

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_eff;
        irq_id_d   = irq_id_q;
        rst_pend_d = rst_pend_q;
        nmi_clear  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sample && (rst_pend_q || nmi_latch_q || irq_ok)) begin
                    state_d  = StPend;
                    irq_id_d = 3'd0;
                    if (rst_pend_q) begin
                        kind_d = KindReset;
                    end else if (nmi_latch_q) begin
                        kind_d = KindNmi;
                    end else begin
                        kind_d   = KindIrq;
                        irq_id_d = cand_id;
                    end
                end
            end
            StPend: begin
                if (vec_lo_stb) begin
                    state_d = StServe;
                    if (kind_eff == KindNmi) begin
                        nmi_clear = 1'b1;
                    end
                    if (kind_eff == KindReset) begin
                        rst_pend_d = 1'b0;
                    end
                end else if (kind_eff == KindIrq && (|irq_pending)) begin
                    irq_id_d = cand_id;
                end
            end
            StServe: begin
                if (vec_hi_stb) begin
                    state_d  = StIdle;
                    kind_d   = KindNone;
                    irq_id_d = 3'd0;
                end
            end
            default: begin
                state_d  = StIdle;
                kind_d   = KindNone;
                irq_id_d = 3'd0;
            end
        endcase
    end

    // A fresh edge in the clearing cycle keeps the latch set
    assign nmi_latch_d = nmi_rise | (nmi_latch_q & ~nmi_clear);
    assign mask_d      = mask_we ? mask_wdata : mask_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            kind_q      <= KindNone;
            irq_id_q    <= 3'd0;
            mask_q      <= '1;
            nmi_sync_q  <= '0;
            nmi_last_q  <= 1'b0;
            nmi_latch_q <= 1'b0;
            rst_pend_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            irq_id_q    <= irq_id_d;
            mask_q      <= mask_d;
            nmi_sync_q  <= nmi_sync_d;
            nmi_last_q  <= nmi_sync_q[NMI_SYNC-1];
            nmi_latch_q <= nmi_latch_d;
            rst_pend_q  <= rst_pend_d;
        end
    end

    always_comb begin
        vector_lo = 8'hFE;
        unique case (kind_eff)
            KindReset: vector_lo = 8'hFC;
            KindNmi:   vector_lo = 8'hFA;
            KindIrq: begin
                if (VECTORED != 0) begin
                    vector_lo = VEC_IRQ_BASE + {4'b0000, irq_id_q, 1'b0};
                end
            end
            default:   vector_lo = 8'hFE;
        endcase
    end

    assign int_req    = (state_q != StIdle);
    assign int_kind   = kind_eff;
    assign push_b     = ~int_req;
    assign wr_inhibit = int_req & (kind_eff == KindReset);
    assign irq_id     = irq_id_q;

endmodule

// File: tb/tb_cpu6502_int_seq.sv
// Self-checking bench for cpu6502_int_seq: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level reference model.
module tb_cpu6502_int_seq;

    localparam int NI = 4;
    localparam int S  = 2;

    logic          clk = 1'b0;
    logic          reset, nmi, i_flag, mask_we, sample, vec_lo_stb, vec_hi_stb;
    logic [NI-1:0] irq_src, mask_wdata;
    logic          int_req, push_b, wr_inhibit;
    logic [1:0]    int_kind;
    logic [7:0]    vector_lo;
    logic [2:0]    irq_id;
    logic [NI-1:0] irq_pending;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit            m_busy      = 0;
    bit            m_vec_done  = 0;
    bit            m_rst_pend  = 0;
    bit            m_nmi       = 0;
    int            m_kind      = 0;
    int            m_id        = 0;
    logic [NI-1:0] m_mask      = '1;
    bit            hist[$];

    always #5 clk = ~clk;

    cpu6502_int_seq #(
        .NUM_IRQ     (NI),
        .VECTORED    (1),
        .VEC_IRQ_BASE(8'hE0),
        .NMI_SYNC    (S)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .nmi        (nmi),
        .irq_src    (irq_src),
        .i_flag     (i_flag),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .sample     (sample),
        .vec_lo_stb (vec_lo_stb),
        .vec_hi_stb (vec_hi_stb),
        .int_req    (int_req),
        .int_kind   (int_kind),
        .vector_lo  (vector_lo),
        .push_b     (push_b),
        .wr_inhibit (wr_inhibit),
        .irq_id     (irq_id),
        .irq_pending(irq_pending)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [NI-1:0] p);
        for (int i = 0; i < NI; i++) begin
            if (p[i]) return i;
        end
        return 0;
    endfunction

    function automatic int eff_kind();
        if (m_busy && !m_vec_done && m_kind == 1 && m_nmi) return 2;
        return m_kind;
    endfunction

    function automatic int exp_vec(input int k);
        case (k)
            3:       return 'hFC;
            2:       return 'hFA;
            1:       return ('hE0 + 2 * m_id) % 256;
            default: return 'hFE;
        endcase
    endfunction

    task automatic check_outputs();
        int k;
        k = eff_kind();
        check_eq("int_req", int'(int_req), int'(m_busy));
        check_eq("int_kind", int'(int_kind), k);
        check_eq("vector_lo", int'(vector_lo), exp_vec(k));
        check_eq("push_b", int'(push_b), int'(!m_busy));
        check_eq("wr_inhibit", int'(wr_inhibit), int'(m_busy && k == 3));
        check_eq("irq_id", int'(irq_id), m_id);
        check_eq("irq_pending", int'(irq_pending), int'(irq_src & ~m_mask));
    endtask

    // Advance the model by one clock using the inputs present at that edge
    task automatic model_update();
        logic [NI-1:0] pend;
        bit irq_ok, rise, clr_nmi;
        int k;
        pend    = irq_src & ~m_mask;
        irq_ok  = (pend != 0) && !i_flag;
        k       = eff_kind();
        rise    = hist[S-1] && !hist[S];
        clr_nmi = 0;
        if (reset) begin
            m_busy = 0; m_vec_done = 0; m_kind = 0; m_id = 0;
            m_mask = '1; m_nmi = 0; m_rst_pend = 1;
            hist = {};
            repeat (S + 1) hist.push_back(1'b0);
            return;
        end
        if (!m_busy) begin
            if (sample && (m_rst_pend || m_nmi || irq_ok)) begin
                m_busy = 1;
                m_vec_done = 0;
                m_id = 0;
                if (m_rst_pend) m_kind = 3;
                else if (m_nmi) m_kind = 2;
                else begin
                    m_kind = 1;
                    m_id = lowest(pend);
                end
            end
        end else if (!m_vec_done) begin
            m_kind = k;
            if (vec_lo_stb) begin
                m_vec_done = 1;
                if (k == 2) clr_nmi = 1;
                if (k == 3) m_rst_pend = 0;
            end else if (k == 1 && pend != 0) begin
                m_id = lowest(pend);
            end
        end else if (vec_hi_stb) begin
            m_busy = 0; m_vec_done = 0; m_kind = 0; m_id = 0;
        end
        m_nmi = rise || (m_nmi && !clr_nmi);
        if (mask_we) m_mask = mask_wdata;
        hist.push_front(nmi);
        void'(hist.pop_back());
    endtask

    task automatic step();
        #1 check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clr();
        reset = 0; sample = 0; vec_lo_stb = 0; vec_hi_stb = 0; mask_we = 0;
    endtask

    task automatic finish_seq();
        vec_lo_stb = 1; step(); vec_lo_stb = 0;
        vec_hi_stb = 1; step(); vec_hi_stb = 0;
    endtask

    task automatic nmi_pulse_and_wait();
        nmi = 1; step(); nmi = 0;
        repeat (S) step();
    endtask

    initial begin
        repeat (S + 1) hist.push_back(1'b0);
        clr();
        nmi = 0; irq_src = '0; i_flag = 0; mask_wdata = '0;
        reset = 1;
        @(negedge clk);
        repeat (3) begin
            @(posedge clk);
            model_update();
        end
        @(negedge clk);
        check_eq("rst_int_req", int'(int_req), 0);
        check_eq("rst_int_kind", int'(int_kind), 0);
        check_eq("rst_vector", int'(vector_lo), 'hFE);
        check_eq("rst_push_b", int'(push_b), 1);
        check_eq("rst_wr_inh", int'(wr_inhibit), 0);
        check_eq("rst_irq_id", int'(irq_id), 0);

        // Power-on RESET sequence
        reset = 0; step();
        sample = 1; step(); sample = 0;
        check_eq("reset_kind", int'(int_kind), 3);
        check_eq("reset_vec", int'(vector_lo), 'hFC);
        check_eq("reset_wrinh", int'(wr_inhibit), 1);
        vec_lo_stb = 1; step(); vec_lo_stb = 0;
        check_eq("reset_wrinh_serve", int'(wr_inhibit), 1);
        vec_hi_stb = 1; step(); vec_hi_stb = 0;
        check_eq("reset_done_req", int'(int_req), 0);
        check_eq("reset_done_wrinh", int'(wr_inhibit), 0);

        // Vectored IRQ from source 2
        mask_we = 1; mask_wdata = '0; step(); mask_we = 0;
        irq_src = 4'b0100; sample = 1; step(); sample = 0;
        check_eq("irq2_kind", int'(int_kind), 1);
        check_eq("irq2_id", int'(irq_id), 2);
        check_eq("irq2_vec", int'(vector_lo), 'hE4);
        check_eq("irq2_push_b", int'(push_b), 0);
        finish_seq();

        // I flag blocks IRQ, NMI still serviced
        irq_src = 4'b0001; i_flag = 1; sample = 1; step(); sample = 0;
        check_eq("iflag_block", int'(int_req), 0);
        nmi_pulse_and_wait();
        sample = 1; step(); sample = 0;
        check_eq("nmi_kind", int'(int_kind), 2);
        check_eq("nmi_vec", int'(vector_lo), 'hFA);
        finish_seq();

        // NMI hijacks a committed IRQ before the vector fetch
        i_flag = 0; sample = 1; step(); sample = 0;
        check_eq("hijack_pre", int'(int_kind), 1);
        nmi_pulse_and_wait();
        check_eq("hijack_kind", int'(int_kind), 2);
        check_eq("hijack_vec", int'(vector_lo), 'hFA);
        finish_seq();
        irq_src = '0; sample = 1; step(); sample = 0;
        check_eq("hijack_latch_clr", int'(int_req), 0);

        // Full mask, then unmask source 3
        irq_src = 4'b1111; mask_we = 1; mask_wdata = 4'b1111; step(); mask_we = 0;
        #1 check_eq("masked_pending", int'(irq_pending), 0);
        sample = 1; step(); sample = 0;
        check_eq("masked_req", int'(int_req), 0);
        mask_we = 1; mask_wdata = 4'b0111; step(); mask_we = 0;
        sample = 1; step(); sample = 0;
        check_eq("unmask_id", int'(irq_id), 3);
        check_eq("unmask_vec", int'(vector_lo), 'hE6);
        finish_seq();
        irq_src = '0;

        // Reset during an NMI service
        nmi_pulse_and_wait();
        sample = 1; step(); sample = 0;
        check_eq("nmi2_kind", int'(int_kind), 2);
        vec_lo_stb = 1; step(); vec_lo_stb = 0;
        reset = 1; step(); reset = 0;
        check_eq("midrst_req", int'(int_req), 0);
        check_eq("midrst_kind", int'(int_kind), 0);
        check_eq("midrst_vec", int'(vector_lo), 'hFE);
        check_eq("midrst_push_b", int'(push_b), 1);
        sample = 1; step(); sample = 0;
        check_eq("midrst_next_kind", int'(int_kind), 3);
        finish_seq();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            reset      = ($urandom_range(0, 99) < 2);
            sample     = ($urandom_range(0, 99) < 30);
            vec_lo_stb = ($urandom_range(0, 99) < 25);
            vec_hi_stb = ($urandom_range(0, 99) < 25);
            mask_we    = ($urandom_range(0, 99) < 8);
            mask_wdata = NI'($urandom);
            i_flag     = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 30) irq_src = NI'($urandom);
            if ($urandom_range(0, 9) == 0) nmi = ~nmi;
            step();
        end

        clr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
